issue_queue_ctrl: RTL and testbench

- Control and tracking half of the integer issue queue. Drives the enable and select lines of the collapsing shift-register storage.
- Keeps a shadow copy of per-slot valid, operand-ready and operand-tag state, and snoops the CDB tag to wake up waiting operands.
- Picks the oldest ready slot and issues it to the integer FU over a valid/ready handshake. Accepts new dispatches only when slot 0 can capture.

---
 rtl/issue_queue_pkg.sv | 24 ++
 rtl/iq_age_picker.sv | 22 ++
 rtl/issue_queue_ctrl.sv | 130 +++++++++++++
 tb/tb_issue_queue_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_queue_pkg.sv
// rtl/issue_queue_pkg.sv - shared constants, slot type and wakeup helper for the integer issue queue
// Also used by the WAKEUP_BYPASS_EN build of issue_queue_ctrl.
package issue_queue_pkg;

  localparam int IQ_DEPTH     = 4;
  localparam int IQ_TAG_WIDTH = 6;

  typedef logic [IQ_TAG_WIDTH-1:0] iq_tag_t;

  typedef struct packed {
    logic    v;
    logic    r1;
    logic    r2;
    iq_tag_t t1;
    iq_tag_t t2;
  } iq_slot_t;

  // A waiting operand wakes when the broadcast tag matches its source tag.
  function automatic logic cdb_hit(input logic cdb_valid, input iq_tag_t cdb_tag,
                                   input logic rdy, input iq_tag_t tag);
    return cdb_valid & ~rdy & (tag == cdb_tag);
  endfunction

endpackage

// File: rtl/iq_age_picker.sv
// rtl/iq_age_picker.sv - one-hot picker favouring the highest-index (oldest) request
// Purely combinational; sel is all-zero when no request is present.
module iq_age_picker #(
  parameter int DEPTH = 4
) (
  input  logic [DEPTH-1:0] req,
  output logic [DEPTH-1:0] sel,
  output logic             any
);

  always_comb begin
    sel = '0;
    any = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--) begin
      if (req[j] && !any) begin
        sel[j] = 1'b1;
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/issue_queue_ctrl.sv
// rtl/issue_queue_ctrl.sv - issue queue control: collapsing shift enables, CDB wakeup, oldest-ready issue
// Optional WAKEUP_BYPASS_EN lets the current CDB tag count as ready in the select logic.
module issue_queue_ctrl
  import issue_queue_pkg::*;
#(
  parameter int DEPTH     = IQ_DEPTH,
  parameter int TAG_WIDTH = IQ_TAG_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dispatch_enable,
  input  logic [TAG_WIDTH-1:0] dispatch_rs1_tag,
  input  logic                 dispatch_rs1_data_val,
  input  logic [TAG_WIDTH-1:0] dispatch_rs2_tag,
  input  logic                 dispatch_rs2_data_val,
  output logic                 dispatch_ready,
  input  logic                 CDB_valid,
  input  logic [TAG_WIDTH-1:0] CDB_tag,
  input  logic                 issue_ready,
  output logic                 issue_valid,
  output logic [DEPTH-1:0]     issue_sel,
  output logic [DEPTH-1:0]     enable_valid,
  output logic [DEPTH-1:0]     enable_opcode,
  output logic [DEPTH-1:0]     enable_rd_tag,
  output logic [DEPTH-1:0]     enable_rs1_tag,
  output logic [DEPTH-1:0]     enable_rs2_tag,
  output logic [DEPTH-1:0]     enable_rs1_data,
  output logic [DEPTH-1:0]     enable_rs2_data,
  output logic [DEPTH-1:0]     enable_rs1_valid,
  output logic [DEPTH-1:0]     enable_rs2_valid,
  output logic [DEPTH-1:0]     sel_rs1,
  output logic [DEPTH-1:0]     sel_rs2,
  output logic                 issueque_full,
  output logic                 issueque_empty
);

  iq_slot_t slot_q [DEPTH];
  iq_slot_t inc    [DEPTH];
  iq_slot_t cand   [DEPTH];
  iq_slot_t nxt    [DEPTH];

  logic [DEPTH-1:0] req, grant, hole, shift, m1, m2, vq;

  // Select sees registered state only, unless bypass folds in the live CDB tag.
  always_comb begin
    req = '0;
    vq  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      vq[j] = slot_q[j].v;
`ifdef WAKEUP_BYPASS_EN
      req[j] = slot_q[j].v
             & (slot_q[j].r1 | (CDB_valid & (slot_q[j].t1 == CDB_tag)))
             & (slot_q[j].r2 | (CDB_valid & (slot_q[j].t2 == CDB_tag)));
`else
      req[j] = slot_q[j].v & slot_q[j].r1 & slot_q[j].r2;
`endif
    end
  end

  iq_age_picker #(.DEPTH(DEPTH)) u_picker (
    .req (req),
    .sel (issue_sel),
    .any (issue_valid)
  );

  assign grant = {DEPTH{issue_valid & issue_ready}} & issue_sel;

  // A slot shifts when it or any older slot is (or is becoming) a hole.
  always_comb begin
    hole  = '0;
    shift = '0;
    for (int j = 0; j < DEPTH; j++) begin
      hole[j] = ~slot_q[j].v | grant[j];
    end
    for (int j = 0; j < DEPTH; j++) begin
      shift[j] = |(hole >> j);
    end
  end

  always_comb begin
    m1 = '0;
    m2 = '0;
    inc[0].v  = dispatch_enable;
    inc[0].r1 = dispatch_rs1_data_val;
    inc[0].r2 = dispatch_rs2_data_val;
    inc[0].t1 = dispatch_rs1_tag;
    inc[0].t2 = dispatch_rs2_tag;
    for (int j = 1; j < DEPTH; j++) begin
      inc[j]   = slot_q[j-1];
      inc[j].v = slot_q[j-1].v & ~grant[j-1];
    end
    // Wakeup is judged on whichever entry will sit in slot j next cycle.
    for (int j = 0; j < DEPTH; j++) begin
      cand[j]   = shift[j] ? inc[j] : slot_q[j];
      m1[j]     = cdb_hit(CDB_valid, CDB_tag, cand[j].r1, cand[j].t1);
      m2[j]     = cdb_hit(CDB_valid, CDB_tag, cand[j].r2, cand[j].t2);
      nxt[j]    = cand[j];
      nxt[j].r1 = cand[j].r1 | m1[j];
      nxt[j].r2 = cand[j].r2 | m2[j];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < DEPTH; j++) begin
        slot_q[j] <= '0;
      end
    end else begin
      for (int j = 0; j < DEPTH; j++) begin
        slot_q[j] <= nxt[j];
      end
    end
  end

  assign enable_valid     = shift;
  assign enable_opcode    = shift;
  assign enable_rd_tag    = shift;
  assign enable_rs1_tag   = shift;
  assign enable_rs2_tag   = shift;
  assign enable_rs1_data  = m1 | shift;
  assign enable_rs2_data  = m2 | shift;
  assign enable_rs1_valid = enable_rs1_data;
  assign enable_rs2_valid = enable_rs2_data;
  assign sel_rs1          = ~m1;
  assign sel_rs2          = ~m2;
  assign dispatch_ready   = shift[0];
  assign issueque_full    = &vq;
  assign issueque_empty   = ~|vq;

endmodule

// File: tb/tb_issue_queue_ctrl.sv
// tb/tb_issue_queue_ctrl.sv - directed bench with a slot-occupancy reference model for issue_queue_ctrl
// Honours WAKEUP_BYPASS_EN when the design is built with it.
module tb_issue_queue_ctrl;

  localparam int D = 4;

  logic       clk, reset;
  logic       dispatch_enable, dispatch_rs1_data_val, dispatch_rs2_data_val;
  logic [5:0] dispatch_rs1_tag, dispatch_rs2_tag;
  logic       dispatch_ready, CDB_valid, issue_ready, issue_valid;
  logic [5:0] CDB_tag;
  logic [D-1:0] issue_sel, enable_valid, enable_opcode, enable_rd_tag, enable_rs1_tag, enable_rs2_tag;
  logic [D-1:0] enable_rs1_data, enable_rs2_data, enable_rs1_valid, enable_rs2_valid, sel_rs1, sel_rs2;
  logic       issueque_full, issueque_empty;

  int total = 0;
  int bad   = 0;

  issue_queue_ctrl dut (
    .clk(clk), .reset(reset),
    .dispatch_enable(dispatch_enable),
    .dispatch_rs1_tag(dispatch_rs1_tag), .dispatch_rs1_data_val(dispatch_rs1_data_val),
    .dispatch_rs2_tag(dispatch_rs2_tag), .dispatch_rs2_data_val(dispatch_rs2_data_val),
    .dispatch_ready(dispatch_ready),
    .CDB_valid(CDB_valid), .CDB_tag(CDB_tag),
    .issue_ready(issue_ready), .issue_valid(issue_valid), .issue_sel(issue_sel),
    .enable_valid(enable_valid), .enable_opcode(enable_opcode), .enable_rd_tag(enable_rd_tag),
    .enable_rs1_tag(enable_rs1_tag), .enable_rs2_tag(enable_rs2_tag),
    .enable_rs1_data(enable_rs1_data), .enable_rs2_data(enable_rs2_data),
    .enable_rs1_valid(enable_rs1_valid), .enable_rs2_valid(enable_rs2_valid),
    .sel_rs1(sel_rs1), .sel_rs2(sel_rs2),
    .issueque_full(issueque_full), .issueque_empty(issueque_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: slot contents by position, including stale contents of empty slots.
  bit         mv [D], mr1 [D], mr2 [D];
  logic [5:0] mt1 [D], mt2 [D];
  bit         nv [D], nr1 [D], nr2 [D];
  logic [5:0] nt1 [D], nt2 [D];
  logic       e_iv, e_dr, e_full, e_empty;
  logic [D-1:0] e_sel, e_shift, e_sel1, e_sel2, e_en1, e_en2;
  int         e_idx, e_top;

  function automatic bit opnd_ok(input bit r, input logic [5:0] t, input logic cv, input logic [5:0] ct);
`ifdef WAKEUP_BYPASS_EN
    return r || (cv && t == ct);
`else
    return r;
`endif
  endfunction

  always_comb begin
    e_iv = 1'b0; e_sel = '0; e_idx = -1; e_top = -1; e_shift = '0;
    e_sel1 = '0; e_sel2 = '0; e_en1 = '0; e_en2 = '0;
    e_full = 1'b1; e_empty = 1'b1;
    for (int j = 0; j < D; j++) begin
      nv[j] = 1'b0; nr1[j] = 1'b0; nr2[j] = 1'b0; nt1[j] = '0; nt2[j] = '0;
    end
    for (int j = D - 1; j >= 0; j--) begin
      if (!e_iv && mv[j] && opnd_ok(mr1[j], mt1[j], CDB_valid, CDB_tag)
                && opnd_ok(mr2[j], mt2[j], CDB_valid, CDB_tag)) begin
        e_iv = 1'b1;
        e_idx = j;
        e_sel = 4'(1 << j);
      end
    end
    for (int j = 0; j < D; j++) begin
      if (mv[j]) e_empty = 1'b0; else e_full = 1'b0;
      if (!mv[j] || (e_iv && issue_ready && j == e_idx)) e_top = j;
    end
    e_dr = (e_top >= 0);
    for (int j = 0; j < D; j++) begin
      if (j > e_top) begin
        nv[j] = mv[j]; nr1[j] = mr1[j]; nr2[j] = mr2[j]; nt1[j] = mt1[j]; nt2[j] = mt2[j];
      end else begin
        e_shift[j] = 1'b1;
        if (j == 0) begin
          nv[0] = dispatch_enable; nr1[0] = dispatch_rs1_data_val; nr2[0] = dispatch_rs2_data_val;
          nt1[0] = dispatch_rs1_tag; nt2[0] = dispatch_rs2_tag;
        end else begin
          nv[j] = mv[j-1] && !(e_iv && issue_ready && (j - 1) == e_idx);
          nr1[j] = mr1[j-1]; nr2[j] = mr2[j-1]; nt1[j] = mt1[j-1]; nt2[j] = mt2[j-1];
        end
      end
      e_sel1[j] = !(CDB_valid && !nr1[j] && nt1[j] == CDB_tag);
      e_sel2[j] = !(CDB_valid && !nr2[j] && nt2[j] == CDB_tag);
      e_en1[j]  = !e_sel1[j] || e_shift[j];
      e_en2[j]  = !e_sel2[j] || e_shift[j];
      if (!e_sel1[j]) nr1[j] = 1'b1;
      if (!e_sel2[j]) nr2[j] = 1'b1;
    end
  end

  always @(posedge clk or negedge reset) begin
    for (int j = 0; j < D; j++) begin
      if (!reset) begin
        mv[j] <= 1'b0; mr1[j] <= 1'b0; mr2[j] <= 1'b0; mt1[j] <= '0; mt2[j] <= '0;
      end else begin
        mv[j] <= nv[j]; mr1[j] <= nr1[j]; mr2[j] <= nr2[j]; mt1[j] <= nt1[j]; mt2[j] <= nt2[j];
      end
    end
  end

  always @(negedge clk) begin
    chk("m_issue_valid", 32'(issue_valid), 32'(e_iv));
    chk("m_issue_sel", 32'(issue_sel), 32'(e_sel));
    chk("m_dispatch_ready", 32'(dispatch_ready), 32'(e_dr));
    chk("m_full", 32'(issueque_full), 32'(e_full));
    chk("m_empty", 32'(issueque_empty), 32'(e_empty));
    chk("m_enable_valid", 32'(enable_valid), 32'(e_shift));
    chk("m_sel_rs1", 32'(sel_rs1), 32'(e_sel1));
    chk("m_sel_rs2", 32'(sel_rs2), 32'(e_sel2));
    chk("m_en_rs1_data", 32'(enable_rs1_data), 32'(e_en1));
    chk("m_en_rs2_data", 32'(enable_rs2_data), 32'(e_en2));
    chk("m_en_rs1_valid", 32'(enable_rs1_valid), 32'(e_en1));
    chk("m_en_rs2_valid", 32'(enable_rs2_valid), 32'(e_en2));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [5:0] t1, input logic v1, input logic [5:0] t2, input logic v2);
    dispatch_enable = 1'b1;
    dispatch_rs1_tag = t1; dispatch_rs1_data_val = v1;
    dispatch_rs2_tag = t2; dispatch_rs2_data_val = v2;
  endtask

  task automatic idle();
    dispatch_enable = 1'b0;
    dispatch_rs1_tag = '0; dispatch_rs1_data_val = 1'b0;
    dispatch_rs2_tag = '0; dispatch_rs2_data_val = 1'b0;
  endtask

  initial begin
    reset = 1'b1; idle(); CDB_valid = 1'b0; CDB_tag = '0; issue_ready = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("rst_issue_valid", 32'(issue_valid), 32'd0);
    chk("rst_issue_sel", 32'(issue_sel), 32'd0);
    chk("rst_full", 32'(issueque_full), 32'd0);
    chk("rst_empty", 32'(issueque_empty), 32'd1);
    chk("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
    chk("rst_enable_rd_tag", 32'(enable_rd_tag), 32'hf);
    chk("rst_enable_opcode", 32'(enable_opcode), 32'hf);
    chk("rst_sel_rs1", 32'(sel_rs1), 32'hf);
    chk("rst_sel_rs2", 32'(sel_rs2), 32'hf);
    tick(); tick();
    reset = 1'b1;

    // Fill with four ready entries while the FU stalls.
    for (int i = 0; i < D; i++) begin
      disp(6'(16 + i), 1'b1, 6'(24 + i), 1'b1);
      tick();
    end
    idle(); #1;
    chk("fill_full", 32'(issueque_full), 32'd1);
    chk("fill_dispatch_ready", 32'(dispatch_ready), 32'd0);
    chk("fill_issue_sel", 32'(issue_sel), 32'h8);
    chk("model_full_pin", 32'(e_full), 32'd1);

    // Issue and dispatch together while full.
    disp(6'd40, 1'b1, 6'd41, 1'b1); issue_ready = 1'b1; #1;
    chk("fd_issue_sel", 32'(issue_sel), 32'h8);
    chk("fd_dispatch_ready", 32'(dispatch_ready), 32'd1);
    chk("fd_enable_rs1_tag", 32'(enable_rs1_tag), 32'hf);
    chk("fd_enable_rs2_tag", 32'(enable_rs2_tag), 32'hf);
    tick();
    idle(); issue_ready = 1'b0; #1;
    chk("fd_full_stays", 32'(issueque_full), 32'd1);

    issue_ready = 1'b1;
    repeat (D) tick();
    issue_ready = 1'b0; #1;
    chk("drain_empty", 32'(issueque_empty), 32'd1);

    // rs1 waits on tag 12; CDB broadcasts it two cycles after dispatch.
    disp(6'd12, 1'b0, 6'd13, 1'b1);
    tick();
    idle();
    tick();
    CDB_valid = 1'b1; CDB_tag = 6'd12; #1;
    chk("wk_sel_rs1", 32'(sel_rs1), 32'hb);
    chk("wk_en_rs1_data", 32'(enable_rs1_data[2]), 32'd1);
`ifdef WAKEUP_BYPASS_EN
    chk("wk_issue_valid_now", 32'(issue_valid), 32'd1);
    chk("wk_issue_sel_now", 32'(issue_sel), 32'h2);
`else
    chk("wk_issue_valid_now", 32'(issue_valid), 32'd0);
    chk("model_iv_pin", 32'(e_iv), 32'd0);
`endif
    tick();
    CDB_valid = 1'b0; #1;
    chk("wk_issue_valid_next", 32'(issue_valid), 32'd1);
    chk("wk_issue_sel_next", 32'(issue_sel), 32'h4);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;

    // CDB matches the dispatching operand in the same cycle.
    disp(6'd4, 1'b1, 6'd5, 1'b0); CDB_valid = 1'b1; CDB_tag = 6'd5; #1;
    chk("cd_sel_rs2_0", 32'(sel_rs2[0]), 32'd0);
    chk("cd_en_rs2_data_0", 32'(enable_rs2_data[0]), 32'd1);
    tick();
    idle(); CDB_valid = 1'b0; #1;
    chk("cd_issue_valid", 32'(issue_valid), 32'd1);
    chk("cd_issue_sel", 32'(issue_sel), 32'h1);
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;

    // Oldest ready wins over a younger ready entry behind a stalled one.
    disp(6'd20, 1'b1, 6'd21, 1'b1); tick();
    disp(6'd30, 1'b0, 6'd22, 1'b1); tick();
    disp(6'd23, 1'b1, 6'd24, 1'b1); tick();
    idle(); tick();
    chk("age_issue_sel", 32'(issue_sel), 32'h8);
    issue_ready = 1'b1; #1;
    chk("age_enable_valid", 32'(enable_valid), 32'hf);
    tick();
    issue_ready = 1'b0; #1;
    chk("age_issue_sel_after", 32'(issue_sel), 32'h4);
    chk("model_sel_pin", 32'(e_sel), 32'h4);

    // Asynchronous reset with three live entries.
    disp(6'd25, 1'b1, 6'd26, 1'b1); tick();
    idle(); #1;
    chk("ar_pre_issue_valid", 32'(issue_valid), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("ar_issue_valid", 32'(issue_valid), 32'd0);
    chk("ar_empty", 32'(issueque_empty), 32'd1);
    chk("ar_dispatch_ready", 32'(dispatch_ready), 32'd1);
    tick();
    reset = 1'b1;
    tick(); tick();
    chk("end_empty", 32'(issueque_empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
